// File: rtl/ppu_ctrl_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : ppu_ctrl_pipeline
// Purpose  : Carries the 22-bit decoded PPU control word and the 5-bit
//            destination register index from ID through the EX, MEM and WB
//            stage registers. It unpacks the fields that each stage consumes
//            and gates every field with that stage's valid bit. It inserts a
//            bubble into EX on a hazard stall, on a branch flush or when ID
//            holds no instruction.
// Ports    : clk, reset_n (synchronous, active-low)
//            id_ctrl[21:0], id_rd[4:0], id_valid  - word arriving from ID
//            stall, flush                         - hazard / branch control
//            ex_*  : src_op, alu_op, b_instr, ta_instr, cond_uncond,
//                    uncond_jump, load_pending, rd
//            mem_* : size, rw, se, en, load, rd
//            wb_*  : rf_en, en_hi, en_lo, r31, destination, rd
//            bubble_count[15:0] - stall/flush bubbles inserted
// Config   : PPU_CTRL_PIPE_STATS_EN - builds the saturating bubble counter.
//            When it is not defined, bubble_count is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module ppu_ctrl_pipeline #(
    parameter int CTRL_W = 22,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              id_valid,
    input  logic              stall,
    input  logic              flush,
    output logic [2:0]        ex_src_op,
    output logic [3:0]        ex_alu_op,
    output logic              ex_b_instr,
    output logic              ex_ta_instr,
    output logic              ex_cond_uncond,
    output logic              ex_uncond_jump,
    output logic              ex_load_pending,
    output logic [REG_W-1:0]  ex_rd,
    output logic [1:0]        mem_size,
    output logic              mem_rw,
    output logic              mem_se,
    output logic              mem_en,
    output logic              mem_load,
    output logic [REG_W-1:0]  mem_rd,
    output logic              wb_rf_en,
    output logic              wb_en_hi,
    output logic              wb_en_lo,
    output logic              wb_r31,
    output logic              wb_destination,
    output logic [REG_W-1:0]  wb_rd,
    output logic [15:0]       bubble_count
);

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    logic [CTRL_W-1:0] r_ex_ctrl, r_mem_ctrl, r_wb_ctrl;
    logic [REG_W-1:0]  r_ex_rd,   r_mem_rd,   r_wb_rd;
    logic              r_ex_valid, r_mem_valid, r_wb_valid;

    // A bubble enters EX whenever ID cannot hand over a real instruction.
    // Stall and flush together still produce only one bubble.
    logic w_bubble;
    assign w_bubble = stall | flush | ~id_valid;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ex_ctrl   <= '0;
            r_ex_rd     <= '0;
            r_ex_valid  <= 1'b0;
            r_mem_ctrl  <= '0;
            r_mem_rd    <= '0;
            r_mem_valid <= 1'b0;
            r_wb_ctrl   <= '0;
            r_wb_rd     <= '0;
            r_wb_valid  <= 1'b0;
        end else begin
            // MEM and WB always advance; only the EX load is held off.
            r_wb_ctrl   <= r_mem_ctrl;
            r_wb_rd     <= r_mem_rd;
            r_wb_valid  <= r_mem_valid;
            r_mem_ctrl  <= r_ex_ctrl;
            r_mem_rd    <= r_ex_rd;
            r_mem_valid <= r_ex_valid;
            if (w_bubble) begin
                r_ex_ctrl  <= '0;
                r_ex_rd    <= '0;
                r_ex_valid <= 1'b0;
            end else begin
                r_ex_ctrl  <= id_ctrl;
                r_ex_rd    <= id_rd;
                r_ex_valid <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // EX fields
    // ------------------------------------------------------------------
    assign ex_cond_uncond  = r_ex_ctrl[21] & r_ex_valid;
    assign ex_uncond_jump  = r_ex_ctrl[19] & r_ex_valid;
    assign ex_src_op       = r_ex_ctrl[17:15] & {3{r_ex_valid}};
    assign ex_alu_op       = r_ex_ctrl[14:11] & {4{r_ex_valid}};
    assign ex_load_pending = r_ex_ctrl[10] & r_ex_valid;
    assign ex_b_instr      = r_ex_ctrl[8] & r_ex_valid;
    assign ex_ta_instr     = r_ex_ctrl[7] & r_ex_valid;
    assign ex_rd           = r_ex_rd & {REG_W{r_ex_valid}};

    // ------------------------------------------------------------------
    // MEM fields
    // ------------------------------------------------------------------
    assign mem_load = r_mem_ctrl[10] & r_mem_valid;
    assign mem_size = r_mem_ctrl[6:5] & {2{r_mem_valid}};
    assign mem_rw   = r_mem_ctrl[4] & r_mem_valid;
    assign mem_se   = r_mem_ctrl[3] & r_mem_valid;
    assign mem_en   = r_mem_ctrl[0] & r_mem_valid;
    assign mem_rd   = r_mem_rd & {REG_W{r_mem_valid}};

    // ------------------------------------------------------------------
    // WB fields
    // ------------------------------------------------------------------
    assign wb_r31         = r_wb_ctrl[20] & r_wb_valid;
    assign wb_destination = r_wb_ctrl[18] & r_wb_valid;
    assign wb_rf_en       = r_wb_ctrl[9] & r_wb_valid;
    assign wb_en_hi       = r_wb_ctrl[2] & r_wb_valid;
    assign wb_en_lo       = r_wb_ctrl[1] & r_wb_valid;
    assign wb_rd          = r_wb_rd & {REG_W{r_wb_valid}};

    // Each stage carries the full word, so some bits are never consumed
    // at a given stage. Folding them here documents that this is on purpose.
    logic w_unused_bits;
    assign w_unused_bits = ^{r_ex_ctrl[20], r_ex_ctrl[18], r_ex_ctrl[9],
                             r_ex_ctrl[6:0],
                             r_mem_ctrl[21:11], r_mem_ctrl[9:7],
                             r_mem_ctrl[2:1],
                             r_wb_ctrl[21], r_wb_ctrl[19], r_wb_ctrl[17:10],
                             r_wb_ctrl[8:3], r_wb_ctrl[0]};

    // ------------------------------------------------------------------
    // Bubble statistics
    // ------------------------------------------------------------------
`ifdef PPU_CTRL_PIPE_STATS_EN
    localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

    logic [15:0] r_bubble_count;
    logic        w_count_event;

    // Only real instructions that get squashed or held back are counted.
    // An empty ID slot is not a hazard bubble.
    assign w_count_event = (stall | flush) & id_valid;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_bubble_count <= '0;
        end else if (w_count_event && (r_bubble_count != C_CNT_MAX)) begin
            r_bubble_count <= r_bubble_count + 16'd1;
        end
    end

    assign bubble_count = r_bubble_count;
`else
    assign bubble_count = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ppu_ctrl_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : tb_ppu_ctrl_pipeline
// Purpose  : Self-checking bench for ppu_ctrl_pipeline. The reference model
//            keeps a history list of the words that entered EX. EX, MEM and
//            WB are taken as history entries 0, 1 and 2. The expected outputs
//            are extracted from those words by field position.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ppu_ctrl_pipeline;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [21:0] id_ctrl;
    logic [4:0]  id_rd;
    logic        id_valid, stall, flush;
    logic [2:0]  ex_src_op;
    logic [3:0]  ex_alu_op;
    logic        ex_b_instr, ex_ta_instr, ex_cond_uncond, ex_uncond_jump;
    logic        ex_load_pending;
    logic [4:0]  ex_rd;
    logic [1:0]  mem_size;
    logic        mem_rw, mem_se, mem_en, mem_load;
    logic [4:0]  mem_rd;
    logic        wb_rf_en, wb_en_hi, wb_en_lo, wb_r31, wb_destination;
    logic [4:0]  wb_rd;
    logic [15:0] bubble_count;

    always #5 clk = ~clk;

    ppu_ctrl_pipeline #(.CTRL_W(22), .REG_W(5)) dut (
        .clk(clk), .reset_n(reset_n),
        .id_ctrl(id_ctrl), .id_rd(id_rd), .id_valid(id_valid),
        .stall(stall), .flush(flush),
        .ex_src_op(ex_src_op), .ex_alu_op(ex_alu_op),
        .ex_b_instr(ex_b_instr), .ex_ta_instr(ex_ta_instr),
        .ex_cond_uncond(ex_cond_uncond), .ex_uncond_jump(ex_uncond_jump),
        .ex_load_pending(ex_load_pending), .ex_rd(ex_rd),
        .mem_size(mem_size), .mem_rw(mem_rw), .mem_se(mem_se),
        .mem_en(mem_en), .mem_load(mem_load), .mem_rd(mem_rd),
        .wb_rf_en(wb_rf_en), .wb_en_hi(wb_en_hi), .wb_en_lo(wb_en_lo),
        .wb_r31(wb_r31), .wb_destination(wb_destination), .wb_rd(wb_rd),
        .bubble_count(bubble_count)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [21:0] w;
        logic [4:0]  rd;
        logic        v;
    } ent_t;

    ent_t        hist[$];          // [0]=EX, [1]=MEM, [2]=WB
    int unsigned model_bubbles;
    ent_t        zero_ent = '{w: 22'd0, rd: 5'd0, v: 1'b0};

    function automatic logic [63:0] ex_exp(input ent_t e);
        logic [21:0] w;
        logic [4:0]  r;
        w = e.v ? e.w : 22'd0;
        r = e.v ? e.rd : 5'd0;
        return {w[17:15], w[14:11], w[8], w[7], w[21], w[19], w[10], r};
    endfunction

    function automatic logic [63:0] mem_exp(input ent_t e);
        logic [21:0] w;
        logic [4:0]  r;
        w = e.v ? e.w : 22'd0;
        r = e.v ? e.rd : 5'd0;
        return {w[6:5], w[4], w[3], w[0], w[10], r};
    endfunction

    function automatic logic [63:0] wb_exp(input ent_t e);
        logic [21:0] w;
        logic [4:0]  r;
        w = e.v ? e.w : 22'd0;
        r = e.v ? e.rd : 5'd0;
        return {w[9], w[2], w[1], w[20], w[18], r};
    endfunction

    function automatic logic [15:0] cnt_exp();
`ifdef PPU_CTRL_PIPE_STATS_EN
        return model_bubbles[15:0];
`else
        return 16'd0;
`endif
    endfunction

    // One clock: drive the inputs, advance the model at the edge, compare after the edge.
    task automatic cycle(input logic [21:0] c, input logic [4:0] rd,
                         input logic v, input logic st, input logic fl,
                         input logic rn);
        ent_t e;
        id_ctrl = c; id_rd = rd; id_valid = v;
        stall = st; flush = fl; reset_n = rn;
        @(posedge clk);
        if (!rn) begin
            hist.delete();
            repeat (3) hist.push_back(zero_ent);
            model_bubbles = 0;
        end else begin
            if (st || fl || !v) e = zero_ent;
            else                e = '{w: c, rd: rd, v: 1'b1};
            hist.push_front(e);
            void'(hist.pop_back());
            if ((st || fl) && v && model_bubbles < 65535) model_bubbles++;
        end
        #1;
        check("ex",  {ex_src_op, ex_alu_op, ex_b_instr, ex_ta_instr,
                      ex_cond_uncond, ex_uncond_jump, ex_load_pending, ex_rd},
              ex_exp(hist[0]));
        check("mem", {mem_size, mem_rw, mem_se, mem_en, mem_load, mem_rd},
              mem_exp(hist[1]));
        check("wb",  {wb_rf_en, wb_en_hi, wb_en_lo, wb_r31, wb_destination,
                      wb_rd}, wb_exp(hist[2]));
        check("bubble_count", bubble_count, cnt_exp());
    endtask

    task automatic idle();
        cycle(22'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    localparam logic [21:0] W_ADDIU = 22'h160600;
    localparam logic [21:0] W_LBU   = 22'h160605;
    localparam logic [21:0] W_SB    = 22'h020017;

    initial begin
        int unsigned r;
        for (int i = 0; i < 3; i++) hist.push_back(zero_ent);
        model_bubbles = 0;
        id_ctrl = '0; id_rd = '0; id_valid = 0; stall = 0; flush = 0;
        reset_n = 0;

        // reset state
        cycle(W_ADDIU, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(W_ADDIU, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);

        // ADDIU through all stages
        cycle(W_ADDIU, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        check("addiu_ex_src_op", ex_src_op, 3'b100);
        check("addiu_ex_alu_op", ex_alu_op, 4'd0);
        idle();
        idle();
        check("addiu_wb", {wb_rf_en, wb_r31, wb_destination, wb_rd},
              {3'b111, 5'd5});
        idle();
        check("addiu_wb_gone", {wb_rf_en, wb_rd}, 6'd0);

        // LBU followed by a stall
        cycle(W_LBU, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1);
        check("lbu_load_pending", {ex_load_pending, ex_rd}, {1'b1, 5'd8});
        cycle(W_ADDIU, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1);
        check("stall_ex_bubble", {ex_src_op, ex_load_pending, ex_rd}, 9'd0);
        check("lbu_mem", {mem_en, mem_se, mem_load, mem_rd},
              {3'b101, 5'd8});
        idle(); idle(); idle();

        // SB squashed by a flush at the same edge, and stall+flush together
        cycle(W_SB, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(); idle();
        cycle(W_SB, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(); idle();

        // back-to-back words with no gaps
        cycle(W_ADDIU, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(W_SB,    5'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(W_LBU,   5'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        check("b2b_rd_chain", {ex_rd, mem_rd, wb_rd}, {5'd3, 5'd2, 5'd1});

        // legal NOP word carried as valid
        cycle(22'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(); idle();
        check("nop_wb_rd", wb_rd, 5'd4);

        // mid-stream reset discards in-flight words
        cycle(W_ADDIU, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(W_LBU,   5'd11, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(W_SB,    5'd12, 1'b1, 1'b1, 1'b0, 1'b0);
        check("reset_all_zero", {ex_rd, mem_rd, wb_rd, wb_rf_en, mem_en},
              17'd0);
        cycle(W_ADDIU, 5'd13, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(); idle();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            cycle(22'($urandom), 5'($urandom), r < 85,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
                  $urandom_range(0, 59) != 0);
        end

`ifdef PPU_CTRL_PIPE_STATS_EN
        // counter saturation
        cycle(W_ADDIU, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 70000; i++)
            cycle(W_LBU, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1);
        check("bubble_sat", bubble_count, 16'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ppu_ctrl_pipeline.md
# ppu_ctrl_pipeline

Carries the 22-bit decoded control word from the PPU control unit (ID stage) through the EX, MEM and WB pipeline registers, together with each instruction's 5-bit destination register index. It unpacks the fields each stage consumes and gates them with a per-stage valid bit. It inserts bubbles on hazard stall or branch flush, and exports EX-stage load/destination information to the hazard unit. It sits between the control unit and the datapath stage logic.

## Interface
- CTRL_W, 22, control word width; field map fixed at 22.
- REG_W, 5, register index width.

- clk  in  1  pipeline clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- id_ctrl  in  22  control word from control unit: [21] cond/uncond, [20] r31, [19] uncond_jump, [18] destination, [17:15] src_op, [14:11] alu_op, [10] load, [9] rf_en, [8] b_instr, [7] ta_instr, [6:5] mem_size, [4] mem_rw, [3] mem_se, [2] en_hi, [1] en_lo, [0] mem_en.
- id_rd  in  5  destination register index chosen in ID.
- id_valid  in  1  ID holds a real instruction.
- stall  in  1  load-use stall from hazard unit.
- flush  in  1  taken branch/jump; squash the ID instruction.
- ex_src_op, ex_alu_op, ex_b_instr, ex_ta_instr, ex_cond_uncond, ex_uncond_jump  out  3/4/1/1/1/1  EX fields.
- ex_load_pending  out  1  EX holds a valid load.
- ex_rd  out  5  EX destination index.
- mem_size, mem_rw, mem_se, mem_en, mem_load  out  2/1/1/1/1  MEM fields.
- mem_rd  out  5  MEM destination index.
- wb_rf_en, wb_en_hi, wb_en_lo, wb_r31, wb_destination  out  1 each  WB fields.
- wb_rd  out  5  WB destination index.
- bubble_count  out  16  bubbles inserted (see Configuration).

## Operation
- Three stage registers: EX, MEM and WB. Each holds a 22-bit control word, a 5-bit rd and a valid bit.
- Every edge: WB←MEM, MEM←EX. Both always advance; they are never stalled.
- EX load, in priority order:
  - reset_n=0 → all stages zero.
  - stall=1 or flush=1 or id_valid=0 → bubble (word 0, rd 0, valid 0).
  - otherwise EX←{id_ctrl, id_rd, 1}.
- stall and flush both asserted → a single bubble. flush never squashes EX, MEM or WB.
- A control word of 0 with id_valid=1 is a legal NOP: it is carried with valid=1, and all enables are 0.
- Every output field is its stage's stored field ANDed with that stage's valid bit. A bubble therefore drives all-zero outputs.
- ex_load_pending = EX.valid & EX.ctrl[10].
- ex_rd, mem_rd and wb_rd are forced to 0 when their stage is invalid.
- The block performs no arithmetic on the fields; they pass through unchanged.

## Timing
- Latency: an ID word sampled at edge N appears on EX outputs after edge N, on MEM outputs after N+1, and on WB outputs after N+2.
- All outputs are registered-stage values ANDed with valid; there are no combinational paths from id_* inputs to outputs.
- stall/flush take effect at the same edge they are sampled.
- Reset is synchronous: while reset_n=0 at an edge, every output is 0 after that edge, including bubble_count. Mid-stream reset discards all in-flight words.
- Throughput: one word per cycle when stall=0 and flush=0.

## Configuration
- PPU_CTRL_PIPE_STATS_EN defined:
  - bubble_count increments by 1 on every edge where a bubble is loaded into EX because of stall or flush while id_valid=1.
  - It saturates at 16'hFFFF and clears on reset.
- Undefined: bubble_count is a constant 0 and no counter logic is built.

## Test plan
- ADDIU word 0x160600, rd=5, id_valid=1 for one cycle → after 1 edge ex_src_op=3'b100, ex_alu_op=0; after 3 edges wb_rf_en=1, wb_r31=1, wb_destination=1, wb_rd=5, then 0.
- LBU 0x160605, rd=8 followed by stall=1 → ex_load_pending=1 and ex_rd=8 while the load is in EX; next cycle EX is a bubble (all EX outputs 0); the load reaches MEM with mem_en=1, mem_se=0, mem_load=1.
- SB 0x020017 with flush=1 at the same edge → EX, MEM and WB outputs stay 0 throughout; with STATS, bubble_count=1.
- Back-to-back words A=0x160600, B=0x020017, C=0x160605 → each appears in EX, MEM and WB on consecutive cycles with no gaps and correct fields.
- reset_n=0 while MEM and WB hold valid words → after the edge all outputs are 0; the next valid ID word flows normally.
- STATS: 70000 cycles with stall=1 and id_valid=1 → bubble_count holds at 16'hFFFF.
